// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle controller: states, opcodes,
// function codes, PC-select and ALU-op codes, and the one-hot instruction class.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_WB     = 4'd3,
        S_MADDR  = 4'd4,
        S_MRD    = 4'd5,
        S_MWR    = 4'd6,
        S_MWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] PCSEL_PC4    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;
    localparam logic [1:0] PCSEL_RS     = 2'b11;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // One-hot instruction class produced by the decoder.
    typedef enum logic [8:0] {
        CLS_R   = 9'b000000001,
        CLS_IMM = 9'b000000010,
        CLS_LW  = 9'b000000100,
        CLS_SW  = 9'b000001000,
        CLS_BEQ = 9'b000010000,
        CLS_J   = 9'b000100000,
        CLS_JAL = 9'b001000000,
        CLS_JR  = 9'b010000000,
        CLS_ILL = 9'b100000000
    } cls_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Request/ready handshakes between the controller and instruction/data memory.
// A request stays high until the memory answers with ready in the same cycle; the
// access completes on exactly that cycle, and memwrite qualifies a data request.
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic memwrite;

    modport master (
        output imem_req,
        output dmem_req,
        output memwrite,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  memwrite,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational op/func classifier: maps the IR opcode and function fields to a
// one-hot instruction class; anything outside the supported subset is CLS_ILL.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output cls_t       cls
);

    always_comb begin
        cls = CLS_ILL;
        case (op)
            OP_RTYPE: begin
                if (func == FN_ADDU || func == FN_SUBU) cls = CLS_R;
                else if (func == FN_JR)                 cls = CLS_JR;
                else                                    cls = CLS_ILL;
            end
            OP_ORI, OP_LUI: cls = CLS_IMM;
            OP_LW:          cls = CLS_LW;
            OP_SW:          cls = CLS_SW;
            OP_BEQ:         cls = CLS_BEQ;
            OP_J:           cls = CLS_J;
            OP_JAL:         cls = CLS_JAL;
            default:        cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle Moore sequencer for the MIPS-lite datapath: state register,
// next-state logic, state-decoded control outputs and the retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    multicycle_ctrl_if.master  mem,
    output logic               pcwrite,
    output logic [1:0]         pcsel,
    output logic               irwrite,
    output logic               mdrwrite,
    output logic               regdst,
    output logic               alusrc,
    output logic               extop,
    output logic [1:0]         aluop,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               jal,
    output logic               illegal,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   instr_count
);

    state_t           state_q;
    cls_t             cls;
    cls_t             cls_q;
    logic [CNT_W-1:0] count_q;
    logic             retire;

    multicycle_ctrl_decode u_decode (
        .op   (op),
        .func (func),
        .cls  (cls)
    );

    assign state       = state_q;
    assign instr_count = count_q;

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_WB, S_MWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MWR:                         retire = mem.dmem_ready;
            default:                       retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_ILL;
            count_q <= '0;
        end else begin
            if (retire) count_q <= count_q + 1'b1;
            case (state_q)
                S_FETCH: if (mem.imem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    cls_q <= cls;
                    case (cls)
                        CLS_R, CLS_IMM:         state_q <= S_EXEC;
                        CLS_LW, CLS_SW:         state_q <= S_MADDR;
                        CLS_BEQ:                state_q <= S_BRANCH;
                        CLS_J, CLS_JAL, CLS_JR: state_q <= S_JUMP;
                        default:                state_q <= S_FETCH;
                    endcase
                end
                S_EXEC:   state_q <= S_WB;
                S_MADDR:  state_q <= (cls_q == CLS_LW) ? S_MRD : S_MWR;
                S_MRD:    if (mem.dmem_ready) state_q <= S_MWB;
                S_MWR:    if (mem.dmem_ready) state_q <= S_FETCH;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Output decode from the state register; reset overrides everything to 0.
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.memwrite = 1'b0;
        pcwrite      = 1'b0;
        pcsel        = PCSEL_PC4;
        irwrite      = 1'b0;
        mdrwrite     = 1'b0;
        regdst       = 1'b0;
        alusrc       = 1'b0;
        extop        = 1'b0;
        aluop        = ALUOP_ADD;
        memtoreg     = 1'b0;
        regwrite     = 1'b0;
        jal          = 1'b0;
        illegal      = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem.imem_req = 1'b1;
                    irwrite      = mem.imem_ready;
                    pcwrite      = mem.imem_ready;
                    pcsel        = PCSEL_PC4;
                end
                S_DECODE: illegal = (cls == CLS_ILL);
                S_EXEC: begin
                    if (cls_q == CLS_R) begin
                        aluop  = ALUOP_FUNC;
                        alusrc = 1'b0;
                    end else begin
                        aluop  = ALUOP_ADD;
                        alusrc = 1'b1;
                        extop  = 1'b0;
                    end
                end
                S_WB: begin
                    regwrite = 1'b1;
                    regdst   = (cls_q == CLS_R);
                end
                S_MADDR: begin
                    alusrc = 1'b1;
                    extop  = 1'b1;
                    aluop  = ALUOP_ADD;
                end
                S_MRD: begin
                    mem.dmem_req = 1'b1;
                    mdrwrite     = mem.dmem_ready;
                end
                S_MWR: begin
                    mem.dmem_req = 1'b1;
                    mem.memwrite = 1'b1;
                end
                S_MWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                    regdst   = 1'b0;
                end
                S_BRANCH: begin
                    aluop   = ALUOP_SUB;
                    alusrc  = 1'b0;
                    pcsel   = PCSEL_BRANCH;
                    pcwrite = zero;
                end
                S_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsel    = (cls_q == CLS_JR) ? PCSEL_RS : PCSEL_JUMP;
                    regwrite = (cls_q == CLS_JAL);
                    jal      = (cls_q == CLS_JAL);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through the
// sequencer cycle by cycle and compares controls and counter against hand values.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic        pcwrite;
    logic [1:0]  pcsel;
    logic        irwrite;
    logic        mdrwrite;
    logic        regdst;
    logic        alusrc;
    logic        extop;
    logic [1:0]  aluop;
    logic        memtoreg;
    logic        regwrite;
    logic        jal;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .func        (func),
        .zero        (zero),
        .mem         (mif),
        .pcwrite     (pcwrite),
        .pcsel       (pcsel),
        .irwrite     (irwrite),
        .mdrwrite    (mdrwrite),
        .regdst      (regdst),
        .alusrc      (alusrc),
        .extop       (extop),
        .aluop       (aluop),
        .memtoreg    (memtoreg),
        .regwrite    (regwrite),
        .jal         (jal),
        .illegal     (illegal),
        .state       (state),
        .instr_count (instr_count)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [8:0] enables();
        return {mif.imem_req, mif.dmem_req, pcwrite, irwrite, mdrwrite,
                regwrite, mif.memwrite, jal, illegal};
    endfunction

    initial begin
        reset = 1'b1;
        op = 6'b0; func = 6'b0; zero = 1'b0;
        mif.imem_ready = 1'b1;
        mif.dmem_ready = 1'b1;

        step(); step();
        check("rst_enables", 32'(enables()), 32'h0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", instr_count, 32'd0);
        reset = 1'b0;
        #1;

        // addu $3,$1,$2
        op = 6'b000000; func = 6'b100001;
        check("addu_fetch_req", 32'({mif.imem_req, irwrite, pcwrite}), 32'b111);
        step(); check("addu_decode", 32'({state, illegal}), {27'b0, 4'd1, 1'b0});
        step(); check("addu_exec", 32'({state, aluop, alusrc}), {25'b0, 4'd2, 2'b10, 1'b0});
        step(); check("addu_wb", 32'({state, regwrite, regdst}), {26'b0, 4'd3, 2'b11});
        check("addu_cnt_before", instr_count, 32'd0);
        step(); check("addu_cnt_after", instr_count, 32'd1);
        check("addu_back_fetch", 32'(state), 32'd0);

        // lw with dmem_ready low for three cycles
        op = 6'b100011; func = 6'b0;
        step(); check("lw_decode", 32'(state), 32'd1);
        step(); check("lw_maddr", 32'({state, alusrc, extop, aluop}), {24'b0, 4'd4, 2'b11, 2'b00});
        mif.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("lw_mrd_wait", 32'({state, mif.dmem_req, mdrwrite}), {26'b0, 4'd5, 2'b10});
        end
        mif.dmem_ready = 1'b1;
        #1;
        check("lw_mrd_ready", 32'({state, mif.dmem_req, mdrwrite}), {26'b0, 4'd5, 2'b11});
        step(); check("lw_mwb", 32'({state, regwrite, memtoreg, regdst}), {25'b0, 4'd7, 3'b110});
        step(); check("lw_cnt", instr_count, 32'd2);

        // beq taken, then not taken
        op = 6'b000100; zero = 1'b1;
        step(); step();
        check("beq_t_branch", 32'({state, pcwrite, pcsel, aluop, alusrc}), {24'b0, 4'd8, 1'b1, 2'b01, 2'b01, 1'b0});
        step(); check("beq_t_cnt", instr_count, 32'd3);
        zero = 1'b0;
        step(); step();
        check("beq_nt_branch", 32'({state, pcwrite, pcsel}), {25'b0, 4'd8, 1'b0, 2'b01});
        step(); check("beq_nt_cnt", instr_count, 32'd4);

        // jal then jr
        op = 6'b000011;
        step(); step();
        check("jal_jump", 32'({state, pcwrite, pcsel, regwrite, jal}), {24'b0, 4'd9, 1'b1, 2'b10, 2'b11});
        step(); check("jal_cnt", instr_count, 32'd5);
        op = 6'b000000; func = 6'b001000;
        step(); step();
        check("jr_jump", 32'({state, pcwrite, pcsel, regwrite, jal}), {24'b0, 4'd9, 1'b1, 2'b11, 2'b00});
        step(); check("jr_cnt", instr_count, 32'd6);

        // ori with one instruction-memory wait cycle
        op = 6'b001101; func = 6'b0;
        mif.imem_ready = 1'b0;
        #1;
        check("ori_fetch_wait", 32'({mif.imem_req, irwrite, pcwrite}), 32'b100);
        step(); check("ori_fetch_hold", 32'(state), 32'd0);
        mif.imem_ready = 1'b1;
        #1;
        check("ori_fetch_ready", 32'({irwrite, pcwrite, pcsel}), 32'b1100);
        step(); step();
        check("ori_exec", 32'({state, aluop, alusrc, extop}), {25'b0, 4'd2, 2'b00, 2'b10});
        step(); check("ori_wb", 32'({state, regwrite, regdst}), {26'b0, 4'd3, 2'b10});
        step(); check("ori_cnt", instr_count, 32'd7);

        // undefined opcode
        op = 6'b111111;
        step(); check("ill_decode", 32'({state, illegal}), {27'b0, 4'd1, 1'b1});
        step(); check("ill_back", 32'({state, illegal}), {27'b0, 4'd0, 1'b0});
        check("ill_cnt", instr_count, 32'd7);

        // reset while a lw waits in MRD
        op = 6'b100011;
        step(); step();
        mif.dmem_ready = 1'b0;
        step(); check("mrd_before_rst", 32'({state, mif.dmem_req}), {27'b0, 4'd5, 1'b1});
        reset = 1'b1;
        #1;
        check("mrd_rst_enables", 32'(enables()), 32'h0);
        step();
        check("mrd_rst_state", 32'(state), 32'd0);
        check("mrd_rst_cnt", instr_count, 32'd0);
        reset = 1'b0;
        mif.dmem_ready = 1'b1;
        #1;

        // counter wrap on a retired sw
        force dut.count_q = 32'hffff_ffff;
        #1;
        release dut.count_q;
        #1;
        check("wrap_preload", instr_count, 32'hffff_ffff);
        op = 6'b101011;
        step(); step();
        step(); check("sw_mwr", 32'({state, mif.dmem_req, mif.memwrite}), {26'b0, 4'd6, 2'b11});
        check("sw_cnt_hold", instr_count, 32'hffff_ffff);
        step(); check("sw_wrap", instr_count, 32'd0);
        check("sw_back_fetch", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
